// File: rtl/polyphase_split_stream.sv
// polyphase_split_stream: split a raster pixel stream into four row/column parity FIFOs
module polyphase_split_stream #(
  parameter int WIDTH      = 16,
  parameter int ROWS       = 224,
  parameter int COLS       = 224,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic                 divide_done,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = ROWS > 2 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 2 ? $clog2(COLS) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [1:0] w_phase;
  logic [3:0] w_full, w_push, w_pop, w_empty_next;
  logic w_accept, w_last, w_col_end, r_busy;
  assign w_phase   = {r_row[0], r_col[0]};
  assign in_ready  = (r_state == RUN) && !w_full[w_phase];
  assign w_accept  = in_valid && in_ready;
  assign w_col_end = r_col == CW'(COLS - 1);
  assign w_last    = w_accept && w_col_end && r_row == RW'(ROWS - 1);
  for (genvar k = 0; k < 4; k++) begin : g_ph
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    assign w_full[k]       = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign out_valid[k]    = r_cnt != '0;
    assign w_push[k]       = w_accept && w_phase == 2'(k);
    assign w_pop[k]        = out_valid[k] && out_ready[k];
    // empty after this edge: nothing pushed and at most the last entry leaving
    assign w_empty_next[k] = !w_push[k] && (r_cnt == '0 || (r_cnt == (AW+1)'(1) && w_pop[k]));
    assign out_data[k*WIDTH +: WIDTH] = out_valid[k] ? r_mem[r_rp] : '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[k]) r_wp <= r_wp + AW'(1);
        if (w_pop[k]) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + (AW+1)'(w_push[k]) - (AW+1)'(w_pop[k]);
      end
    always_ff @(posedge clk)
      if (w_push[k]) r_mem[r_wp] <= in_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= RUN;
    else r_state <= w_next;
  always_comb
    w_next = r_state == RUN   ? (w_last ? DRAIN : RUN) :
             r_state == DRAIN ? (&w_empty_next ? DONE : DRAIN) : RUN;
  always_comb begin
    divide_done = r_state == DONE;
    busy        = r_busy;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col <= w_col_end ? '0 : r_col + CW'(1);
        r_row <= w_last ? '0 : w_col_end ? r_row + RW'(1) : r_row;
      end
      r_busy <= w_next == DONE ? 1'b0 : w_accept ? 1'b1 : r_busy;
    end
endmodule

// File: tb/tb_polyphase_split_stream.sv
// tb_polyphase_split_stream: directed scenarios checked against a queue-based model
module tb_polyphase_split_stream;
  localparam int W = 16, R = 4, C = 4, D = 2;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, divide_done, busy;
  logic [W-1:0] in_data = '0;
  logic [3:0] out_valid, out_ready = 4'b1111;
  logic [4*W-1:0] out_data;
  int vectors = 0, miscompares = 0, done_cnt = 0, acc_cnt = 0;
  bit tog = 0;
  logic [W-1:0] mq [4][$];
  logic [W-1:0] dlog [4][$];
  int m_idx = 0;
  bit m_drain = 0, m_busy = 0;
  int lit [4][4] = '{'{0, 2, 8, 10}, '{1, 3, 9, 11}, '{4, 6, 12, 14}, '{5, 7, 13, 15}};

  polyphase_split_stream #(.WIDTH(W), .ROWS(R), .COLS(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .divide_done(divide_done), .busy(busy));

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic int phase_of(int idx);
    int r = idx / C, c = idx % C;
    return r[0] * 2 + c[0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        dlog[k].delete();
      end
      m_idx = 0; m_drain = 0; m_busy = 0; done_cnt = 0; acc_cnt = 0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_done", 64'(divide_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      bit e_done, e_rdy;
      logic [3:0] e_valid;
      logic [4*W-1:0] e_data;
      int ph;
      e_done = m_drain && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0;
      if (e_done) m_busy = 0;
      ph = phase_of(m_idx);
      e_rdy = !m_drain && mq[ph].size() < D;
      e_data = '0;
      for (int k = 0; k < 4; k++) begin
        e_valid[k] = mq[k].size() > 0;
        if (e_valid[k]) e_data[k*W +: W] = mq[k][0];
      end
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("out_data", out_data, e_data);
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("divide_done", 64'(divide_done), 64'(e_done));
      chk("busy", 64'(busy), 64'(m_busy));
      for (int k = 0; k < 4; k++)
        if (out_valid[k] && out_ready[k]) dlog[k].push_back(out_data[k*W +: W]);
      if (divide_done) done_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      for (int k = 0; k < 4; k++)
        if (e_valid[k] && out_ready[k]) void'(mq[k].pop_front());
      if (in_valid && e_rdy) begin
        mq[ph].push_back(in_data);
        m_busy = 1;
        m_idx++;
        if (m_idx == R * C) begin
          m_idx = 0;
          m_drain = 1;
        end
      end
      if (e_done) m_drain = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic rst_pulse();
    in_valid = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic send(input logic [W-1:0] v);
    bit acc;
    int n = 0;
    in_valid = 1;
    in_data = v;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_streams(input int base, input int frames);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lane%0d_len", k), 64'(dlog[k].size()), 64'(4 * frames));
      for (int f = 0; f < frames; f++)
        for (int j = 0; j < 4; j++)
          if (f * 4 + j < dlog[k].size())
            chk($sformatf("lane%0d_item%0d", k, f * 4 + j), 64'(dlog[k][f * 4 + j]),
                64'(lit[k][j] + 16 * f + base));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: straight frame, all lanes ready
    rst_pulse();
    for (int i = 0; i < 16; i++) send(W'(i));
    in_valid = 0;
    wait_done(1);
    check_streams(0, 1);
    // 2: eo lane stalled until the eo FIFO backs up the input
    rst_pulse();
    out_ready = 4'b1101;
    for (int i = 0; i < 9; i++) send(W'(i));
    in_valid = 1;
    in_data = W'(9);
    repeat (10) tick();
    @(negedge clk);
    chk("s2_stall_ready", 64'(in_ready), 64'd0);
    chk("s2_accepted", 64'(acc_cnt), 64'd9);
    chk("s2_eo_head", 64'(out_data[W +: W]), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    for (int i = 9; i < 16; i++) send(W'(i));
    in_valid = 0;
    wait_done(1);
    check_streams(0, 1);
    // 3: abort frame A with a one-cycle reset, then send frame B
    rst_pulse();
    for (int i = 0; i < 6; i++) send(W'(i));
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 16; i++) send(W'(100 + i));
    in_valid = 0;
    wait_done(1);
    check_streams(100, 1);
    // 4: two frames back to back, output ready toggling
    rst_pulse();
    tog = 1;
    for (int i = 0; i < 32; i++) send(W'(i));
    in_valid = 0;
    wait_done(2);
    tog = 0;
    out_ready = 4'b1111;
    check_streams(0, 2);
    // 5: idle after reset
    rst_pulse();
    repeat (100) tick();
    @(negedge clk);
    chk("s5_done_count", 64'(done_cnt), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    // 6: signed extremes pass bit-exact
    rst_pulse();
    for (int i = 0; i < 16; i++) send(i == 0 ? 16'h8000 : i == 5 ? 16'h7FFF : W'(i));
    in_valid = 0;
    wait_done(1);
    chk("s6_ee_min", 64'(dlog[0].size() > 0 ? dlog[0][0] : 16'h0), 64'h8000);
    chk("s6_oo_max", 64'(dlog[3].size() > 0 ? dlog[3][0] : 16'h0), 64'h7FFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/polyphase_split_stream.md
Name: polyphase_split_stream

Overview:
- Front-end stage of the Winograd convolution path, placed directly upstream of the four per-phase tail filters and the summing stage.
- Accepts one raster-order pixel stream of a ROWS x COLS single-channel image.
- Demultiplexes each pixel into one of four polyphase sub-image streams (even-even, even-odd, odd-even, odd-odd) by row/column parity; each phase has its own FIFO.
- Emits a one-cycle divide_done pulse when a full frame has been split and fully drained.

Parameters:
- WIDTH, 16, pixel bit width (signed, passed through unchanged).
- ROWS, 224, image rows; must be even, >= 2.
- COLS, 224, image columns; must be even, >= 2.
- FIFO_DEPTH, 4, entries per phase FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid & in_ready.
- in_data  in  WIDTH  input pixel, raster order, row 0 col 0 first.
- out_valid  out  4  per-phase valid; bit0=ee, bit1=eo, bit2=oe, bit3=oo.
- out_ready  in  4  per-phase ready, same bit order.
- out_data  out  4*WIDTH  lane k = bits [k*WIDTH +: WIDTH].
- divide_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high from first accepted pixel of a frame until divide_done.

Behaviour:
- Reset, asynchronous on rst high: row=0, col=0, FIFOs empty, state RUN, out_valid=0, out_data=0, divide_done=0, busy=0. in_ready follows from the empty FIFOs (1 in RUN).
- Phase selection: phase = {row[0], col[0]}, giving 0=ee, 1=eo, 2=oe, 3=oo.
- in_ready in RUN = !full[phase]. in_ready=0 in DRAIN and DONE.
- Full FIFO is decided by fill level only; a same-cycle pop does not allow a push into a full FIFO.
- Accept: push in_data into FIFO[phase], then update counters:
  - col++; at col==COLS-1, col wraps to 0 and row++.
  - On acceptance of the pixel at row ROWS-1, col COLS-1: row=col=0, state goes to DRAIN.
- Output: out_valid[k] = FIFO k non-empty. out_data lane k = FIFO k head when valid, 0 when empty.
- Pop on out_valid[k] & out_ready[k]. Head data is stable while valid and not ready.
- Latency: a pixel pushed in cycle N is visible at the output (out_valid high) in cycle N+1.
- Simultaneous push and pop on a non-full FIFO: both occur; the count is unchanged.
- Order within each phase is strict FIFO, i.e. sub-image raster order.
- State machine:
  - RUN: accept pixels. Go to DRAIN on the last pixel.
  - DRAIN: no input accepted. Go to DONE in the cycle after all four FIFOs become empty.
  - DONE: divide_done=1 for exactly this cycle, busy drops with it, then return to RUN.
- busy: set on the first acceptance of a frame, cleared in DONE.
- Back-to-back frames: the next frame's first pixel is accepted no earlier than the cycle after DONE.
- Reset mid-frame: all buffered data is discarded. The next accepted pixel is treated as row 0, col 0. No divide_done is issued for the aborted frame.
- No arithmetic: data is passed bit-exact, with no sign extension or truncation.

Test Plan:
1. ROWS=COLS=4, DEPTH=4, out_ready=4'b1111, inputs 0..15 back-to-back -> expected streams:
   - ee: 0, 2, 8, 10
   - eo: 1, 3, 9, 11
   - oe: 4, 6, 12, 14
   - oo: 5, 7, 13, 15
   - Each value appears at the output 1 cycle after it is accepted.
   - divide_done pulses once, the cycle after the final pop; busy is high throughout.
2. DEPTH=2, out_ready=4'b1101 (eo stalled), inputs 0..15 -> expected:
   - Pixels 0..8 are accepted.
   - in_ready=0 while pixel 9 is presented; eo holds 1 (head), 3.
   - Releasing out_ready[1] lets pixel 9 in on the cycle after the first eo pop.
   - All streams end identical to scenario 1.
3. After 6 pixels of frame A, pulse rst for 1 cycle, then send a new frame 100..115 -> expected:
   - All outputs are zero during reset.
   - ee: 100, 102, 108, 110 only; no frame-A data appears.
   - Exactly one divide_done.
4. Two frames back-to-back with in_valid held high, out_ready toggled 1/0 each cycle -> expected:
   - in_ready=0 from the last pixel of frame 1 through DONE.
   - Frame 2 pixel 0 lands in ee after the divide_done pulse.
   - Two divide_done pulses total.
5. in_valid=0 throughout after reset -> expected: out_valid=0, busy=0, and divide_done never asserts for 100 cycles.
6. Signed extremes: in_data=16'h8000 at (0,0) and 16'h7FFF at (1,1) -> expected: ee lane emits 16'h8000 and oo lane emits 16'h7FFF, bit-exact.
